// File: rtl/dma_in_data_if.sv
// rtl/dma_in_data_if.sv - beat input, PE FIFO write and status bundle for dma_in_data
interface dma_in_data_if #(
    parameter int NUM_PE = 4
);
    logic                   i_data_valid;
    logic [133:0]           i_data;
    logic                   o_ready;
    logic [NUM_PE-1:0]      o_wren_low16b;
    logic [NUM_PE*20-1:0]   o_din_low16b;
    logic [NUM_PE-1:0]      o_wren_high16b;
    logic [NUM_PE*17-1:0]   o_din_high16b;
    logic [NUM_PE-1:0]      i_alf_16b;
    logic [NUM_PE-1:0]      i_pe_en;
    logic                   o_err;
    logic [3:0]             d_state_in_4b;

    modport master (
        output i_data_valid, i_data, i_alf_16b, i_pe_en,
        input  o_ready, o_wren_low16b, o_din_low16b, o_wren_high16b, o_din_high16b,
               o_err, d_state_in_4b
    );

    modport slave (
        input  i_data_valid, i_data, i_alf_16b, i_pe_en,
        output o_ready, o_wren_low16b, o_din_low16b, o_wren_high16b, o_din_high16b,
               o_err, d_state_in_4b
    );
endinterface

// File: rtl/dma_in_data.sv
// rtl/dma_in_data.sv - splits 128b beats into four 32b words for round-robin PE FIFO pairs
module dma_in_data #(
    parameter int NUM_PE = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    dma_in_data_if.slave  bus
);
    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic [1:0] {IDLE_S = 2'd0, WR_S = 2'd1, HOLD_S = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [127:0]         buf_q;
    logic [3:0]           valid_tag;
    logic [1:0]           cnt;
    logic [IW-1:0]        rr, tgt, sel;
    logic [NUM_PE-1:0]    avail;
    logic                 ready, head_take, load, wr_en, wr_end, err_nxt;
    logic [31:0]          wr_word;
    logic [NUM_PE-1:0]    wren_nxt;
    logic [NUM_PE*20-1:0] din_low_nxt;
    logic [NUM_PE*17-1:0] din_high_nxt;
    logic [NUM_PE-1:0]    wren_q;
    logic [NUM_PE*20-1:0] din_low_q;
    logic [NUM_PE*17-1:0] din_high_q;
    logic                 err_q;

    assign avail = bus.i_pe_en & ~bus.i_alf_16b;

    // Pick the eligible PE closest to rr going upward with wrap.
    always_comb begin
        int best_d;
        int d;
        best_d = NUM_PE;
        d      = 0;
        sel    = rr;
        for (int i = 0; i < NUM_PE; i++) begin
            if (avail[i]) begin
                d = i - int'(rr);
                if (d < 0) d = d + NUM_PE;
                if (d < best_d) begin
                    best_d = d;
                    sel    = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE_S;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        head_take = 1'b0;
        load      = 1'b0;
        wr_en     = 1'b0;
        wr_end    = 1'b0;
        wr_word   = '0;
        err_nxt   = 1'b0;
        case (state)
            IDLE_S: begin
                ready = |avail;
                if (bus.i_data_valid && ready) begin
                    if (bus.i_data[133:132] == T_HEAD) begin
                        head_take = 1'b1;
                        load      = 1'b1;
                        state_nxt = WR_S;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WR_S: begin
                wr_en = 1'b1;
                case (cnt)
                    2'd0:    wr_word = buf_q[127:96];
                    2'd1:    wr_word = buf_q[95:64];
                    default: wr_word = buf_q[63:32];
                endcase
                if (cnt == 2'd2) state_nxt = HOLD_S;
            end
            HOLD_S: begin
                ready = 1'b1;
                if (bus.i_data_valid) begin
                    wr_en   = 1'b1;
                    wr_word = buf_q[31:0];
                    case (bus.i_data[133:132])
                        T_HEAD: begin
                            wr_end    = 1'b1;
                            err_nxt   = 1'b1;
                            state_nxt = IDLE_S;
                        end
                        T_TAIL: begin
                            wr_end    = 1'b1;
                            state_nxt = IDLE_S;
                        end
                        default: begin
                            load      = 1'b1;
                            state_nxt = WR_S;
                        end
                    endcase
                end
            end
            default: state_nxt = IDLE_S;
        endcase
    end

    always_comb begin
        wren_nxt     = '0;
        din_low_nxt  = '0;
        din_high_nxt = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (wr_en && tgt == IW'(i)) begin
                wren_nxt[i]            = 1'b1;
                din_low_nxt[20*i+:20]  = {valid_tag, wr_word[15:0]};
                din_high_nxt[17*i+:17] = {wr_end, wr_word[31:16]};
            end
        end
    end

    // Target and tag are only captured on a head; bodies reuse them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_q      <= '0;
            valid_tag  <= '0;
            cnt        <= '0;
            rr         <= '0;
            tgt        <= '0;
            wren_q     <= '0;
            din_low_q  <= '0;
            din_high_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (load) begin
                buf_q <= bus.i_data[127:0];
                cnt   <= '0;
            end else if (state == WR_S) begin
                cnt <= cnt + 2'd1;
            end
            if (head_take) begin
                valid_tag <= bus.i_data[131:128];
                tgt       <= sel;
                rr        <= IW'((int'(sel) + 1) % NUM_PE);
            end
            wren_q     <= wren_nxt;
            din_low_q  <= din_low_nxt;
            din_high_q <= din_high_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.o_ready        = ready;
    assign bus.o_wren_low16b  = wren_q;
    assign bus.o_wren_high16b = wren_q;
    assign bus.o_din_low16b   = din_low_q;
    assign bus.o_din_high16b  = din_high_q;
    assign bus.o_err          = err_q;
    assign bus.d_state_in_4b  = {2'b00, state};
endmodule

// File: tb/tb_dma_in_data.sv
// tb/tb_dma_in_data.sv - scoreboard bench for dma_in_data
module tb_dma_in_data;
    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b00;
    localparam logic [1:0] TAIL = 2'b11;

    typedef struct {
        int          pe;
        logic [16:0] hi;
        logic [19:0] lo;
    } wr_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    dma_in_data_if #(.NUM_PE(4)) bus();
    dma_in_data #(.NUM_PE(4)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    wr_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           wr_cnt = 0;
    int           obs_err = 0;
    int           exp_err = 0;
    logic         prev_err = 1'b0;
    logic         in_pkt = 1'b0;
    logic         gap_chk = 1'b0;
    int           last_acc = 0;
    int           m_pe = 0;
    logic [3:0]   m_tag = '0;
    logic [127:0] m_pl = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        wr_t         e;
        logic [79:0] elo;
        logic [67:0] ehi;
        logic [3:0]  eoh;
        if (bus.o_err) obs_err++;
        if (bus.o_err && prev_err) chk("err_pulse_width", 2, 1);
        prev_err = bus.o_err;
        if (bus.o_wren_low16b != 0 || bus.o_wren_high16b != 0) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {bus.o_wren_high16b, bus.o_wren_low16b}, 0);
            end else begin
                e   = exp_q.pop_front();
                elo = '0;
                ehi = '0;
                eoh = '0;
                elo[20*e.pe+:20] = e.lo;
                ehi[17*e.pe+:17] = e.hi;
                eoh[e.pe] = 1'b1;
                chk("wren_low", bus.o_wren_low16b, eoh);
                chk("wren_high", bus.o_wren_high16b, eoh);
                chk("din_low", bus.o_din_low16b, elo);
                chk("din_high", bus.o_din_high16b, ehi);
            end
        end
    end

    task automatic push_word(input int pe, input logic [127:0] pl, input int k,
                             input logic [3:0] tag, input logic endt);
        logic [31:0] w;
        w = pl[127-32*k -: 32];
        exp_q.push_back('{pe, {endt, w[31:16]}, {tag, w[15:0]}});
    endtask

    // Presents a beat and returns at the accepting rising edge, or acc=-1 on timeout.
    task automatic drive(input logic [1:0] typ, input logic [3:0] tag, input logic [127:0] pl,
                         output int acc);
        int n;
        n = 0;
        bus.i_data_valid = 1'b1;
        bus.i_data = {typ, tag, pl};
        #1;
        while (!bus.o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (!bus.o_ready) begin
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1 for beat type %b", typ);
            bus.i_data_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge i_clk);
            acc = cyc;
        end
    endtask

    task automatic send(input logic [1:0] typ, input logic [3:0] tag, input logic [127:0] pl,
                        input int pe);
        int acc;
        drive(typ, tag, pl, acc);
        if (acc >= 0) begin
            if (!in_pkt) begin
                if (typ == HEAD) begin
                    for (int k = 0; k < 3; k++) push_word(pe, pl, k, tag, 1'b0);
                    in_pkt = 1'b1;
                    m_pl   = pl;
                    m_pe   = pe;
                    m_tag  = tag;
                end else begin
                    exp_err++;
                end
            end else begin
                if (gap_chk) chk("beat_gap", acc - last_acc, 4);
                push_word(m_pe, m_pl, 3, m_tag, typ != BODY);
                if (typ == BODY) begin
                    for (int k = 0; k < 3; k++) push_word(m_pe, pl, k, m_tag, 1'b0);
                    m_pl = pl;
                end else begin
                    in_pkt = 1'b0;
                    if (typ == HEAD) exp_err++;
                end
            end
            last_acc = acc;
            @(negedge i_clk);
            bus.i_data_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst  = 1'b0;
        in_pkt = 1'b0;
        wr_cnt = 0;
    endtask

    task automatic drain(input string name, input int exp_writes);
        repeat (10) @(negedge i_clk);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_write_count"}, wr_cnt, exp_writes);
    endtask

    initial begin
        int hi_cnt;
        int acc;
        bus.i_data_valid = 1'b0;
        bus.i_data       = '0;
        bus.i_alf_16b    = '0;
        bus.i_pe_en      = '0;

        @(negedge i_clk);
        chk("rst_wren_low", bus.o_wren_low16b, 0);
        chk("rst_wren_high", bus.o_wren_high16b, 0);
        chk("rst_din_low", bus.o_din_low16b, 0);
        chk("rst_din_high", bus.o_din_high16b, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_state", bus.d_state_in_4b, 0);
        chk("rst_ready_no_pe", bus.o_ready, 0);
        bus.i_pe_en = 4'b1111;
        do_reset();
        chk("idle_ready", bus.o_ready, 1);

        // Single-beat packet to PE0
        send(HEAD, 4'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
        chk("wr_state", bus.d_state_in_4b, 1);
        send(TAIL, 4'd0, 128'h0, 0);
        drain("single", 4);

        // Head, two bodies, tail back to back
        do_reset();
        gap_chk = 1'b1;
        send(HEAD, 4'hA, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
        send(BODY, 4'h0, 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444, 0);
        send(BODY, 4'h0, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0, 0);
        send(TAIL, 4'h0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0);
        gap_chk = 1'b0;
        drain("multi", 12);

        // Round robin
        do_reset();
        for (int p = 0; p < 3; p++) begin
            send(HEAD, 4'(p + 1), {4{32'h1000_0001 * (p + 1)}}, p);
            send(TAIL, 4'h0, 128'h0, p);
        end
        bus.i_alf_16b = 4'b0010;
        send(HEAD, 4'h7, 128'h3333_0000_3333_1111_3333_2222_3333_3333, 3);
        send(TAIL, 4'h0, 128'h0, 3);
        send(HEAD, 4'h8, 128'h4444_0000_4444_1111_4444_2222_4444_3333, 0);
        send(TAIL, 4'h0, 128'h0, 0);
        send(HEAD, 4'h9, 128'h5555_0000_5555_1111_5555_2222_5555_3333, 2);
        send(TAIL, 4'h0, 128'h0, 2);
        drain("round_robin", 24);

        // Backpressure: every PE almost full, then PE2 frees up
        do_reset();
        bus.i_alf_16b    = 4'b1111;
        bus.i_data_valid = 1'b1;
        bus.i_data       = {HEAD, 4'h2, 128'hABCD_0123_ABCD_4567_ABCD_89AB_ABCD_CDEF};
        hi_cnt = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (bus.o_ready) hi_cnt++;
        end
        chk("bp_ready_cycles", hi_cnt, 0);
        chk("bp_state_idle", bus.d_state_in_4b, 0);
        bus.i_alf_16b = 4'b1011;
        send(HEAD, 4'h2, 128'hABCD_0123_ABCD_4567_ABCD_89AB_ABCD_CDEF, 2);
        send(TAIL, 4'h0, 128'h0, 2);
        bus.i_alf_16b = 4'b0000;
        drain("backpressure", 4);

        // Framing errors: body in idle, then head while holding word3 (rr now 3)
        wr_cnt = 0;
        send(BODY, 4'h0, 128'h1234, 0);
        drain("body_in_idle", 0);
        chk("err_count_idle_body", obs_err, exp_err);
        send(HEAD, 4'hC, 128'h0A0B_0C0D_1A1B_1C1D_2A2B_2C2D_3A3B_3C3D, 3);
        send(HEAD, 4'h5, 128'h9999_9999_9999_9999_9999_9999_9999_9999, 3);
        drain("head_in_hold", 4);
        chk("err_count_head_hold", obs_err, exp_err);
        chk("state_after_err", bus.d_state_in_4b, 0);

        // Reset after word1 of a packet
        do_reset();
        drive(HEAD, 4'h6, 128'h7777_0000_7777_1111_7777_2222_7777_3333, acc);
        push_word(0, 128'h7777_0000_7777_1111_7777_2222_7777_3333, 0, 4'h6, 1'b0);
        push_word(0, 128'h7777_0000_7777_1111_7777_2222_7777_3333, 1, 4'h6, 1'b0);
        @(negedge i_clk);
        bus.i_data_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        chk("abort_wren", bus.o_wren_low16b, 0);
        chk("abort_state", bus.d_state_in_4b, 0);
        @(negedge i_clk);
        i_rst  = 1'b0;
        in_pkt = 1'b0;
        drain("abort", 2);
        wr_cnt = 0;
        send(HEAD, 4'h1, 128'h8888_0000_8888_1111_8888_2222_8888_3333, 0);
        send(TAIL, 4'h0, 128'h0, 0);
        drain("after_abort", 4);
        chk("err_count_final", obs_err, exp_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dma_in_data.md
DMA_IN_DATA -- requirements
Module: dma_in_data

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, giving the number of PE 16b-FIFO pairs served (1..4).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  asynchronous active-high reset.
REQ-005 i_data_valid  input  1  134b beat present on i_data.
REQ-006 i_data  input  134  [133:132] beat type: 01 head, 00 body, 11 tail. [131:128] validTag (meaningful on the head beat only). [127:0] payload (tail payload is ignored).
REQ-007 o_ready  output  1  beat accepted on an edge where i_data_valid and o_ready are both 1.
REQ-008 o_wren_low16b  output  NUM_PE  per-PE write enable, low FIFO.
REQ-009 o_din_low16b  output  NUM_PE*20  per-PE {validTag[3:0], low16}, slice i at [20*i+:20].
REQ-010 o_wren_high16b  output  NUM_PE  per-PE write enable, high FIFO.
REQ-011 o_din_high16b  output  NUM_PE*17  per-PE {endTag, high16}, slice i at [17*i+:17].
REQ-012 i_alf_16b  input  NUM_PE  PE FIFO pair almost full; the PE cannot take a new packet.
REQ-013 i_pe_en  input  NUM_PE  PE enabled as a packet target.
REQ-014 o_err  output  1  one-cycle pulse on a framing error.
REQ-015 d_state_in_4b  output  4  current state code, for debug.

Function
REQ-016 States SHALL be IDLE_S=0, WR_S=1, HOLD_S=2; the debug code is zero-extended to 4b.
REQ-017 In IDLE_S, o_ready SHALL equal |(i_pe_en & ~i_alf_16b) (combinational); in WR_S it SHALL be 0; in HOLD_S it SHALL be 1.
REQ-018 Target select on head acceptance: round-robin.
  - Search starts at pointer rr and covers PEs with i_pe_en=1 and i_alf_16b=0.
  - After selection, rr = (selected+1) mod NUM_PE.
  - Target is fixed for the whole packet; i_alf_16b is ignored mid-packet.
REQ-019 On head acceptance in IDLE_S, the block SHALL:
  - latch the payload into a 128b buffer;
  - latch validTag;
  - load word counter = 0;
  - go to WR_S.
REQ-020 Word k (k=0..3) of the buffer SHALL be payload[127-32k -: 32].
  - high16 = word[31:16], low16 = word[15:0].
  - Both FIFOs of the target are written in the same cycle.
REQ-021 Word order and timing:
  - WR_S: one edge each registers word0, word1, word2 (wren=1, endTag=0); after word2, go to HOLD_S.
  - Word3 is held in HOLD_S until the next beat is accepted.
REQ-022 HOLD_S, body accepted:
  - register word3 with endTag=0;
  - load the new payload, counter = 0;
  - go to WR_S.
  - Sustained throughput is 1 beat per 4 cycles.
REQ-023 HOLD_S, tail accepted: register word3 with endTag=1, go to IDLE_S.
REQ-024 HOLD_S, head accepted (framing error):
  - register word3 with endTag=1;
  - discard the beat;
  - pulse o_err;
  - go to IDLE_S.
REQ-025 IDLE_S, body or tail accepted (accepted only when o_ready=1): discard the beat, pulse o_err, no FIFO writes.
REQ-026 validTag latched at the head SHALL be placed on every low word of the packet; endTag SHALL be 1 only on the last word.
REQ-027 Exactly one PE's wren bits SHALL be 1 in any cycle, and o_wren_low16b SHALL always equal o_wren_high16b.
  - Non-target din slices SHALL be 0.
  - wren SHALL be 0 in every cycle not listed in REQ-021..024.
REQ-028 Every packet SHALL produce 4*N writes for N data beats (head + bodies).

Reset
REQ-029 While i_rst=1, the block SHALL hold:
  - all wren, din, o_err = 0;
  - state IDLE_S, rr = 0;
  - buffer, validTag, counter = 0.
REQ-030 Reset asserted mid-packet SHALL abort immediately with no further writes; no endTag is issued for the aborted packet.

Verification
REQ-031 Single-beat packet: PE0 idle; head with payload 0x00112233_44556677_8899AABB_CCDDEEFF and validTag=3, then tail.
  - Expect 4 writes to PE0: high/low 0011/2233, 4455/6677, 8899/AABB, CCDD/EEFF.
  - validTag=3 on all four low words; endTag only on the 4th word.
REQ-032 Head, 2 bodies, tail back-to-back: 12 writes, o_ready low 3 of every 4 cycles, endTag only on write 12.
REQ-033 Round-robin: all PEs enabled, three 1-beat packets go to PE0, PE1, PE2; then set i_alf_16b=4'b0010 and send three more packets.
  - Expect PE3, PE0, PE2.
REQ-034 Backpressure: i_alf_16b=4'b1111 with a head pending gives o_ready=0 indefinitely.
  - Clearing bit 2 gives acceptance and writes to PE2.
REQ-035 Framing errors:
  - body beat in IDLE_S: o_err=1 for 1 cycle, zero writes.
  - head during HOLD_S: pending word3 written with endTag=1, o_err=1, head dropped.
REQ-036 Reset pulse after word1 of a packet: wren=0 from that cycle, state 0, next head goes to PE0.
